// File: rtl/bucket_chunk_sequencer_pkg.sv
// Shared constants for the bucket chunk sequencer.
// Chunk/bucket geometry and counter widths.
package bucket_chunk_sequencer_pkg;

  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int ChunkWidth  = 512;
  localparam int NChunks     = 6;
  localparam int CountWidth  = log2(NChunks);
  localparam int OffsetWidth = 8;
  localparam int OffsetStep  = 4;
  localparam int BucketWidth = NChunks * ChunkWidth;

endpackage

// File: rtl/bucket_chunk_sequencer_if.sv
// Stream bundle between a bucket source and the sequencer.
// master: drives control/bucket/mask; slave: drives count/done/offset/chunk.
interface bucket_chunk_sequencer_if;
  import bucket_chunk_sequencer_pkg::*;

  logic                   enable;
  logic                   offset_set;
  logic                   offset_load;
  logic [OffsetWidth-1:0] offset_in;
  logic [BucketWidth-1:0] bucket_in;
  logic [BucketWidth-1:0] mask_in;
  logic                   mask_enable;
  logic [CountWidth-1:0]  chunk_count;
  logic                   chunk_done;
  logic [OffsetWidth-1:0] offset;
  logic [ChunkWidth-1:0]  chunk_out;

  modport master (
    output enable, offset_set, offset_load, offset_in,
    output bucket_in, mask_in, mask_enable,
    input  chunk_count, chunk_done, offset, chunk_out
  );

  modport slave (
    input  enable, offset_set, offset_load, offset_in,
    input  bucket_in, mask_in, mask_enable,
    output chunk_count, chunk_done, offset, chunk_out
  );

endinterface

// File: rtl/bucket_chunk_sequencer_chunk_mux.sv
// Binary-select chunk multiplexer over a packed port vector.
// Ports: din (NPorts*Width), sel, dout; out-of-range select gives zero.
module bucket_chunk_sequencer_chunk_mux #(
  parameter int Width    = 512,
  parameter int NPorts   = 6,
  parameter int SelWidth = 3
) (
  input  logic [NPorts*Width-1:0] din,
  input  logic [SelWidth-1:0]     sel,
  output logic [Width-1:0]        dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < NPorts; i++) begin
      if (sel == SelWidth'(i)) dout = din[i*Width +: Width];
    end
  end

endmodule

// File: rtl/bucket_chunk_sequencer.sv
// Streams a bucket image one chunk per enabled cycle, with offset tracking.
// Ports: clk, rst_n (async active-low), bus (slave modport).
module bucket_chunk_sequencer
  import bucket_chunk_sequencer_pkg::*;
(
  input logic                     clk,
  input logic                     rst_n,
  bucket_chunk_sequencer_if.slave bus
);

  localparam logic [CountWidth-1:0] LastChunk = CountWidth'(NChunks - 1);

  logic [CountWidth-1:0]  count;
  logic [OffsetWidth-1:0] offset;
  logic                   done;
  logic [ChunkWidth-1:0]  data_chunk;
  logic [ChunkWidth-1:0]  mask_chunk;

  assign done = bus.enable && (count == LastChunk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (bus.enable) begin
      if (count == LastChunk) count <= '0;
      else count <= count + CountWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset <= '0;
    end else if (bus.offset_set) begin
      offset <= '1;
    end else if (bus.offset_load) begin
      offset <= bus.offset_in;
    end else if (done) begin
      offset <= offset + OffsetWidth'(OffsetStep);
    end
  end

  bucket_chunk_sequencer_chunk_mux #(
    .Width    (ChunkWidth),
    .NPorts   (NChunks),
    .SelWidth (CountWidth)
  ) u_data_mux (
    .din  (bus.bucket_in),
    .sel  (count),
    .dout (data_chunk)
  );

  bucket_chunk_sequencer_chunk_mux #(
    .Width    (ChunkWidth),
    .NPorts   (NChunks),
    .SelWidth (CountWidth)
  ) u_mask_mux (
    .din  (bus.mask_in),
    .sel  (count),
    .dout (mask_chunk)
  );

  assign bus.chunk_count = count;
  assign bus.chunk_done  = done;
  assign bus.offset      = offset;
  assign bus.chunk_out   = data_chunk ^
                           (bus.mask_enable ? mask_chunk : '0);

endmodule

// File: tb/tb_bucket_chunk_sequencer.sv
// Directed bench for bucket_chunk_sequencer.
// Hand-computed expectations for counters, offset and chunk mux.
module tb_bucket_chunk_sequencer;
  import bucket_chunk_sequencer_pkg::*;

  localparam int W = 512;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  bucket_chunk_sequencer_if bus();

  bucket_chunk_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pat(input int k);
    logic [7:0] b;
    b = 8'(k + 1);
    return {64{b}};
  endfunction

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b0;
    bus.enable      = 1'b0;
    bus.offset_set  = 1'b0;
    bus.offset_load = 1'b0;
    bus.offset_in   = '0;
    bus.bucket_in   = '0;
    bus.mask_in     = '0;
    bus.mask_enable = 1'b0;
    tick();
    check("rst_cnt", W'(bus.chunk_count), W'(0));
    check("rst_off", W'(bus.offset), W'(0));
    check("rst_done", W'(bus.chunk_done), W'(0));
    tick();
    rst_n = 1'b1;

    // free run for 12 cycles
    bus.enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("run_cnt", W'(bus.chunk_count), W'(i % 6));
      check("run_done", W'(bus.chunk_done), W'(i % 6 == 5));
      check("run_off", W'(bus.offset), W'(4 * (i / 6)));
      tick();
    end
    check("run_cnt12", W'(bus.chunk_count), W'(0));
    check("run_off12", W'(bus.offset), W'(8));

    // enable gating
    for (int i = 0; i < 5; i++) tick();
    bus.enable = 1'b0;
    #1;
    check("gate_done0", W'(bus.chunk_done), W'(0));
    tick();
    check("gate_hold", W'(bus.chunk_count), W'(5));
    check("gate_off", W'(bus.offset), W'(8));
    bus.enable = 1'b1;
    #1;
    check("gate_done1", W'(bus.chunk_done), W'(1));
    tick();
    check("gate_wrap", W'(bus.chunk_count), W'(0));
    check("gate_off12", W'(bus.offset), W'(12));
    bus.enable = 1'b0;
    tick();
    check("gate_hold0", W'(bus.chunk_count), W'(0));
    bus.enable = 1'b1;
    tick();
    check("gate_adv1", W'(bus.chunk_count), W'(1));
    bus.enable = 1'b0;

    // load then wrap on bucket completion
    bus.offset_load = 1'b1;
    bus.offset_in   = 8'hFE;
    tick();
    check("load_fe", W'(bus.offset), W'(8'hFE));
    bus.offset_load = 1'b0;
    bus.offset_in   = 8'h55;
    bus.enable      = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("load_hold", W'(bus.offset), W'(8'hFE));
    tick();
    check("load_wrap", W'(bus.offset), W'(8'h02));
    check("load_cnt", W'(bus.chunk_count), W'(0));

    // set beats load beats done
    for (int i = 0; i < 5; i++) tick();
    check("pri_cnt5", W'(bus.chunk_count), W'(5));
    bus.offset_set  = 1'b1;
    bus.offset_load = 1'b1;
    bus.offset_in   = 8'h10;
    #1;
    check("pri_done", W'(bus.chunk_done), W'(1));
    tick();
    check("pri_set", W'(bus.offset), W'(8'hFF));
    check("pri_wrap", W'(bus.chunk_count), W'(0));
    bus.offset_set = 1'b0;
    bus.offset_load = 1'b0;

    // load beats done
    for (int i = 0; i < 5; i++) tick();
    bus.offset_load = 1'b1;
    bus.offset_in   = 8'h20;
    tick();
    check("pri_load", W'(bus.offset), W'(8'h20));
    bus.offset_load = 1'b0;
    bus.enable      = 1'b0;

    // chunk mux, with and without mask
    for (int k = 0; k < NChunks; k++)
      bus.bucket_in[k*W +: W] = pat(k);
    bus.mask_in = '1;
    for (int k = 0; k < NChunks; k++) begin
      bus.mask_enable = 1'b0;
      #1;
      check("mux_data", bus.chunk_out, pat(k));
      bus.mask_enable = 1'b1;
      #1;
      check("mux_mask", bus.chunk_out, ~pat(k));
      bus.enable = 1'b1;
      tick();
      bus.enable = 1'b0;
    end
    bus.mask_enable = 1'b0;
    check("mux_off", W'(bus.offset), W'(8'h24));

    // async reset mid-bucket
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("mid_cnt3", W'(bus.chunk_count), W'(3));
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_cnt", W'(bus.chunk_count), W'(0));
    check("arst_off", W'(bus.offset), W'(0));
    check("arst_out", bus.chunk_out, pat(0));
    #1;
    rst_n = 1'b1;
    tick();
    check("post_cnt", W'(bus.chunk_count), W'(1));
    check("post_off", W'(bus.offset), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
